gray_codec: RTL and testbench

GRAY_CODEC -- requirements
Module: gray_codec

---
 rtl/gray_codec_pkg.sv | 42 ++++
 rtl/gray_adj_check.sv | 54 +++++
 rtl/gray_codec.sv | 81 ++++++++
 tb/tb_gray_codec.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_codec_pkg.sv
// Shared mode constants and width-generic Gray conversion helpers for gray_codec.
// Words are carried zero-extended in a fixed-size container, so WIDTH may not exceed GRAY_MAX_WIDTH.
package gray_codec_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  localparam int unsigned GRAY_MAX_WIDTH = 64;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  // g[i] = b[i] ^ b[i+1], with the MSB of the active width passed through.
  function automatic gray_word_t bin2gray(input gray_word_t b, input int width);
    gray_word_t g;
    logic       upper;
    g     = '0;
    upper = 1'b0;
    for (int i = GRAY_MAX_WIDTH - 1; i >= 0; i--) begin
      if (i < width) begin
        g[i]  = b[i] ^ upper;
        upper = b[i];
      end
    end
    return g;
  endfunction

  // Prefix XOR from the MSB of the active width down to bit 0.
  function automatic gray_word_t gray2bin(input gray_word_t g, input int width);
    gray_word_t b;
    logic       acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_WIDTH - 1; i >= 0; i--) begin
      if (i < width) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_adj_check.sv
// Gray adjacency checker: remembers the last decoded input word and raises a sticky
// error when the next decoded word differs from it in more than one bit.
module gray_adj_check
  import gray_codec_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_data,
  input  logic             err_clr,
  output logic             err
);

  logic [WIDTH-1:0] hist_q, hist_d;
  logic             hist_valid_q, hist_valid_d;
  logic             err_q, err_d;
  logic             err_set;

  always_comb begin
    hist_d       = hist_q;
    hist_valid_d = hist_valid_q;
    err_set      = 1'b0;
    if (chk_valid) begin
      err_set      = hist_valid_q && ($countones(chk_data ^ hist_q) > 1);
      hist_d       = chk_data;
      hist_valid_d = 1'b1;
    end
    // A new error outranks a clear in the same cycle.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q       <= '0;
      hist_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      hist_valid_q <= hist_valid_d;
      err_q        <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/gray_codec.sv
// Single-stage streaming binary<->Gray converter with valid/ready handshakes.
// Define GRAY_CODEC_ADJ_CHECK_EN to enable the sticky Gray adjacency checker on decode inputs.
module gray_codec
  import gray_codec_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             err_adj,
  input  logic             err_clr
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_mode_q;
  logic             in_xfer;
  gray_word_t       in_word;
  gray_word_t       conv_full;
  logic             unused_conv_hi;

  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    in_word              = '0;
    in_word[WIDTH-1:0]   = in_data;
    if (in_mode == MODE_G2B) begin
      conv_full = gray2bin(in_word, int'(WIDTH));
    end else begin
      conv_full = bin2gray(in_word, int'(WIDTH));
    end
  end

  // Bits above WIDTH are always zero; fold them so they are not left dangling.
  assign unused_conv_hi = ^conv_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= MODE_B2G;
    end else if (in_xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= conv_full[WIDTH-1:0];
      out_mode_q  <= in_mode;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;

`ifdef GRAY_CODEC_ADJ_CHECK_EN
  gray_adj_check #(
    .WIDTH(WIDTH)
  ) u_adj_check (
    .clk      (clk),
    .rst_n    (rst_n),
    .chk_valid(in_xfer && (in_mode == MODE_G2B)),
    .chk_data (in_data),
    .err_clr  (err_clr),
    .err      (err_adj)
  );
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_adj        = 1'b0;
`endif

endmodule

// File: tb/tb_gray_codec.sv
// Scoreboard bench for gray_codec: stimulus pushes expected results, a monitor pops and compares.
module tb_gray_codec;
  localparam int W = 4;
`ifdef GRAY_CODEC_ADJ_CHECK_EN
  localparam bit ADJ = 1'b1;
`else
  localparam bit ADJ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_mode = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b1;
  logic         err_clr = 1'b0;
  logic         in_ready, out_valid, out_mode, err_adj;
  logic [W-1:0] out_data;

  gray_codec #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mode (out_mode),
    .err_adj  (err_adj),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         mode;
    logic [W-1:0] data;
  } res_t;

  res_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  logic         m_err = 1'b0;
  logic         m_hv = 1'b0;
  logic [W-1:0] m_hist = '0;

  // Reference model: Gray code of n is n ^ (n >> 1); decode by searching for the preimage.
  function automatic logic [W-1:0] ref_enc(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] ref_dec(input logic [W-1:0] g);
    for (int x = 0; x < (1 << W); x++) begin
      if (ref_enc(x[W-1:0]) == g) return x[W-1:0];
    end
    return '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_xfer(input logic mode, input logic [W-1:0] d);
    res_t r;
    r.mode = mode;
    r.data = mode ? ref_dec(d) : ref_enc(d);
    sb.push_back(r);
    if (ADJ && mode) begin
      if (m_hv && $countones(d ^ m_hist) > 1) m_err = 1'b1;
      m_hist = d;
      m_hv   = 1'b1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic mode, input logic [W-1:0] d, input bit rnd_ready);
    int  waited = 0;
    bit  done = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = d;
    while (!done) begin
      if (rnd_ready) out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        model_xfer(mode, d);
        done = 1;
      end else begin
        waited++;
        if (waited > 50) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
          done = 1;
        end
        @(posedge clk);
      end
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk);
    m_err = 1'b0;
    #1 err_clr = 1'b0;
  endtask

  // Monitor: pops on each output transfer, checks hold stability and the sticky error flag.
  logic         hold_q = 1'b0;
  logic [W-1:0] held_data;
  logic         held_mode;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(held_data));
        check("hold_mode", 32'(out_mode), 32'(held_mode));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data %0h with empty scoreboard", out_data);
        end else begin
          res_t e;
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_mode", 32'(out_mode), 32'(e.mode));
        end
      end
      check("err_adj", 32'(err_adj), 32'(m_err));
      hold_q    = out_valid && !out_ready;
      held_data = out_data;
      held_mode = out_mode;
    end
  end

  initial begin
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_adj", 32'(err_adj), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Encode and decode of single words.
    send(1'b0, 4'b1011, 0);
    check("enc_valid", 32'(out_valid), 32'd1);
    check("enc_data", 32'(out_data), 32'b1110);
    check("enc_mode", 32'(out_mode), 32'd0);
    send(1'b1, 4'b1110, 0);
    check("dec_data", 32'(out_data), 32'b1011);
    check("dec_mode", 32'(out_mode), 32'd1);

    // Back-to-back encode of 0..15.
    for (int i = 0; i < 16; i++) send(1'b0, W'(i), 0);
    check("b2b_last", 32'(out_data), 32'd8);
    @(posedge clk);
    #1;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: hold one result, offer another word for 5 cycles.
    out_ready = 1'b0;
    send(1'b0, 4'b0101, 0);
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_data", 32'(out_data), 32'b0111);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    model_xfer(1'b0, 4'b0011);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-stream with a pending result and (when enabled) a raised error.
    out_ready = 1'b0;
    send(1'b1, 4'b0001, 0);
    check("pre_rst_err", 32'(err_adj), 32'(ADJ));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_err", 32'(err_adj), 32'd0);
    sb.delete();
    m_err = 1'b0;
    m_hv  = 1'b0;
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Adjacency: first decode after reset never flags.
    send(1'b1, 4'b0000, 0);
    check("adj_first", 32'(err_adj), 32'd0);
    send(1'b1, 4'b0011, 0);
    check("adj_jump", 32'(err_adj), 32'(ADJ));
    clear_err();
    check("adj_clr", 32'(err_adj), 32'd0);
    send(1'b1, 4'b0010, 0);
    check("adj_step", 32'(err_adj), 32'd0);
    send(1'b1, 4'b0010, 0);
    check("adj_repeat", 32'(err_adj), 32'd0);

    // Randomised traffic with random backpressure and occasional clears.
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(1)), W'($urandom), 1);
      if ($urandom_range(15) == 0) clear_err();
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    check("final_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
